// File: rtl/matrix_store_pkg.sv
// rtl/matrix_store_pkg.sv - shared constants and state encoding for the matrix store block
package matrix_store_pkg;

    localparam int ELEM_W  = 8;
    localparam int N_ELEM  = 25;
    localparam int N_WORDS = (N_ELEM + 1) / 2;
    localparam int AW      = 9;

    // A memory word carries two element slices side by side.
    localparam int WORD_W  = 16;
    localparam int HALF_W  = WORD_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic int words_for(input int n_elem);
        return (n_elem + 1) / 2;
    endfunction

endpackage

// File: rtl/matrix_pack_word.sv
// rtl/matrix_pack_word.sv - selects two adjacent matrix elements and packs them into one memory word
module matrix_pack_word #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 25,
    parameter int KW     = 4
) (
    input  logic [ELEM_W*N_ELEM-1:0] matrix,
    input  logic [KW-1:0]            k,
    output logic [15:0]              word
);
    import matrix_store_pkg::*;

    logic [ELEM_W-1:0] lo;
    logic [ELEM_W-1:0] hi;

    // Element 2k goes low, 2k+1 goes high; a missing odd partner reads as zero.
    always_comb begin
        lo = '0;
        hi = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (i == 2 * int'(k))
                lo = matrix[i*ELEM_W +: ELEM_W];
            if (i == 2 * int'(k) + 1)
                hi = matrix[i*ELEM_W +: ELEM_W];
        end
        word = {HALF_W'(hi), HALF_W'(lo)};
    end

endmodule

// File: rtl/matrix_store.sv
// rtl/matrix_store.sv - streams a snapshotted result matrix to memory as packed 16-bit words
module matrix_store #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 25,
    parameter int AW     = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [AW-1:0]            base_addr,
    input  logic [ELEM_W*N_ELEM-1:0] matrix_C,
    input  logic                     mem_ready,
    output logic                     mem_wr,
    output logic [AW-1:0]            mem_addr,
    output logic [15:0]              mem_wdata,
    output logic                     busy,
    output logic                     done
);
    import matrix_store_pkg::*;

    localparam int NW = words_for(N_ELEM);
    localparam int KW = $clog2(NW + 1);
    localparam logic [KW-1:0] LAST_K = KW'(NW - 1);

    state_t                     state;
    logic [KW-1:0]              k;
    logic [KW-1:0]              k_next;
    logic [KW-1:0]              word_idx;
    logic [AW-1:0]              base_q;
    logic [ELEM_W*N_ELEM-1:0]   shadow;
    logic [15:0]                word;

    // While a word is on the bus the packer already looks one word ahead,
    // so the next word can be registered on the same edge the current one completes.
    assign k_next   = k + KW'(1);
    assign word_idx = mem_wr ? k_next : k;

    matrix_pack_word #(
        .ELEM_W (ELEM_W),
        .N_ELEM (N_ELEM),
        .KW     (KW)
    ) u_pack (
        .matrix (shadow),
        .k      (word_idx),
        .word   (word)
    );

    // Snapshot of the matrix taken with an accepted start; later input changes are invisible.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start)
            shadow <= matrix_C;
    end

    // Control FSM: the first WRITE cycle loads the bus, then each accepted write advances k.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            k         <= '0;
            base_q    <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= ST_WRITE;
                        base_q <= base_addr;
                        k      <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!mem_wr) begin
                        mem_wr    <= 1'b1;
                        mem_addr  <= base_q + AW'(k);
                        mem_wdata <= word;
                    end else if (mem_ready) begin
                        if (k == LAST_K) begin
                            state  <= ST_FINISH;
                            mem_wr <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            k         <= k_next;
                            mem_addr  <= base_q + AW'(k_next);
                            mem_wdata <= word;
                        end
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_store.sv
// tb/tb_matrix_store.sv - self-checking bench for matrix_store
module tb_matrix_store;
    localparam int ELEM_W = 8;
    localparam int N_ELEM = 25;
    localparam int AW     = 9;
    localparam int NW     = 13;
    localparam int MW     = ELEM_W * N_ELEM;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [MW-1:0] matrix_C;
    logic          mem_ready;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy;
    logic          done;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  done_q[$];
    int  busy_q[$];
    wr_t mon_w;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int s;

    matrix_store #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .matrix_C  (matrix_C),
        .mem_ready (mem_ready),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wr === 1'b1 && mem_ready === 1'b1) begin
            mon_w.c = cyc;
            mon_w.a = mem_addr;
            mon_w.d = mem_wdata;
            obs_q.push_back(mon_w);
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (busy === 1'b1) busy_q.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [MW-1:0] ramp_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < N_ELEM; i++) m[i*8 +: 8] = 8'(i + 1);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < N_ELEM; i++) m[i*8 +: 8] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    function automatic logic [15:0] exp_word(input logic [MW-1:0] m, input int k);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = m[(2*k)*8 +: 8];
        hi = 8'h00;
        if (2*k + 1 < N_ELEM) hi = m[(2*k+1)*8 +: 8];
        return {hi, lo};
    endfunction

    // Expected write k lands in cycle c0+2+k, pushed back by stall_n cycles from word stall_k on.
    task automatic push_exp(input int base, input logic [MW-1:0] m, input int c0,
                            input int nw, input int stall_k, input int stall_n);
        wr_t e;
        for (int k = 0; k < nw; k++) begin
            e.c = c0 + 2 + k + ((k >= stall_k) ? stall_n : 0);
            e.a = AW'((base + k) % 512);
            e.d = exp_word(m, k);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [MW-1:0] m);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        matrix_C  = m;
        s         = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
        base_addr = '0; matrix_C = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (mem_addr !== 9'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_wdata: got %h want 0000", mem_wdata); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int oi, oi0, di, bi, cnt, first, last;
        wr_t e, o;
        logic [MW-1:0] m;
        m = ramp_mat(); mem_ready = 1'b1;
        oi = obs_q.size(); oi0 = oi; di = done_q.size(); bi = busy_q.size();
        do_start(9'h040, m);
        push_exp(9'h040, m, s, NW, NW, 0);
        for (int i = 0; i < 40 && done_q.size() == di; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++; if (done_q.size() != di + 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_q.size() - di); end
        if (done_q.size() > di) begin
            n_cmp++; if (done_q[di] != s + 15) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 15", done_q[di] - s); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (oi >= obs_q.size()) begin n_fail++; $display("FAIL basic_missing_write: addr %h data %h not seen", e.a, e.d); end
            else begin
                o = obs_q[oi]; oi++;
                if (o.c != e.c || o.a !== e.a || o.d !== e.d) begin
                    n_fail++; $display("FAIL basic_write: got c%0d %h %h want c%0d %h %h", o.c - s, o.a, o.d, e.c - s, e.a, e.d);
                end
            end
        end
        n_cmp++; if (oi != obs_q.size()) begin n_fail++; $display("FAIL basic_extra_writes: got %0d extra want 0", obs_q.size() - oi); end
        if (obs_q.size() >= oi0 + NW) begin
            n_cmp++; if (obs_q[oi0].d !== 16'h0201) begin n_fail++; $display("FAIL basic_first_word: got %h want 0201", obs_q[oi0].d); end
            n_cmp++; if (obs_q[oi0+12].d !== 16'h0019) begin n_fail++; $display("FAIL basic_last_word: got %h want 0019", obs_q[oi0+12].d); end
        end
        cnt = 0; first = -1; last = -1;
        for (int i = bi; i < busy_q.size(); i++) begin
            if (busy_q[i] >= s && busy_q[i] <= s + 20) begin
                cnt++;
                if (first < 0) first = busy_q[i];
                last = busy_q[i];
            end
        end
        n_cmp++;
        if (cnt != 14 || first != s + 1 || last != s + 14) begin
            n_fail++; $display("FAIL basic_busy: got %0d cycles %0d..%0d want 14 cycles 1..14", cnt, first - s, last - s);
        end
    endtask

    task automatic test_stall();
        int oi, di, rel;
        wr_t e, o;
        logic [MW-1:0] m;
        m = ramp_mat(); mem_ready = 1'b1;
        oi = obs_q.size(); di = done_q.size();
        do_start(9'h040, m);
        push_exp(9'h040, m, s, NW, 5, 3);
        for (int i = 0; i < 40 && done_q.size() == di; i++) begin
            rel = cyc - s;
            mem_ready = !(rel >= 7 && rel <= 9);
            @(negedge clk);
            if (rel >= 7 && rel <= 10) begin
                n_cmp++;
                if (mem_wr !== 1'b1 || mem_addr !== 9'h045 || mem_wdata !== 16'h0C0B) begin
                    n_fail++; $display("FAIL stall_hold c%0d: got %b %h %h want 1 045 0C0B", rel, mem_wr, mem_addr, mem_wdata);
                end
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_q.size() != di + 1 || done_q[di] != s + 18) begin
            n_fail++; $display("FAIL stall_done: got %0d pulses want one at cycle 18", done_q.size() - di);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (oi >= obs_q.size()) begin n_fail++; $display("FAIL stall_missing_write: addr %h not seen", e.a); end
            else begin
                o = obs_q[oi]; oi++;
                if (o.c != e.c || o.a !== e.a || o.d !== e.d) begin
                    n_fail++; $display("FAIL stall_write: got c%0d %h %h want c%0d %h %h", o.c - s, o.a, o.d, e.c - s, e.a, e.d);
                end
            end
        end
        n_cmp++; if (oi != obs_q.size()) begin n_fail++; $display("FAIL stall_extra_writes: got %0d want 0", obs_q.size() - oi); end
    endtask

    task automatic test_wrap();
        int oi, oi0, di;
        wr_t e, o;
        logic [MW-1:0] m;
        m = rand_mat(); mem_ready = 1'b1;
        oi = obs_q.size(); oi0 = oi; di = done_q.size();
        do_start(9'h1FA, m);
        push_exp(9'h1FA, m, s, NW, NW, 0);
        for (int i = 0; i < 40 && done_q.size() == di; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++; if (done_q.size() != di + 1) begin n_fail++; $display("FAIL wrap_done: got %0d pulses want 1", done_q.size() - di); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (oi >= obs_q.size()) begin n_fail++; $display("FAIL wrap_missing_write: addr %h not seen", e.a); end
            else begin
                o = obs_q[oi]; oi++;
                if (o.c != e.c || o.a !== e.a || o.d !== e.d) begin
                    n_fail++; $display("FAIL wrap_write: got c%0d %h %h want c%0d %h %h", o.c - s, o.a, o.d, e.c - s, e.a, e.d);
                end
            end
        end
        if (obs_q.size() > oi0 + 6) begin
            n_cmp++; if (obs_q[oi0+6].a !== 9'h000) begin n_fail++; $display("FAIL wrap_zero: got %h want 000", obs_q[oi0+6].a); end
        end
        n_cmp++; if (oi != obs_q.size()) begin n_fail++; $display("FAIL wrap_extra_writes: got %0d want 0", obs_q.size() - oi); end
    endtask

    task automatic test_ignore_start();
        int oi, di, rel;
        wr_t e, o;
        logic [MW-1:0] m;
        m = rand_mat(); mem_ready = 1'b1;
        oi = obs_q.size(); di = done_q.size();
        do_start(9'h020, m);
        push_exp(9'h020, m, s, NW, NW, 0);
        for (int i = 0; i < 40; i++) begin
            rel = cyc - s;
            if (rel == 5) begin start = 1'b1; matrix_C = rand_mat(); base_addr = 9'h100; end
            if (rel == 6) start = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done_q.size() != di + 1 || done_q[di] != s + 15) begin
            n_fail++; $display("FAIL ignore_done: got %0d pulses want one at cycle 15", done_q.size() - di);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (oi >= obs_q.size()) begin n_fail++; $display("FAIL ignore_missing_write: addr %h not seen", e.a); end
            else begin
                o = obs_q[oi]; oi++;
                if (o.c != e.c || o.a !== e.a || o.d !== e.d) begin
                    n_fail++; $display("FAIL ignore_write: got c%0d %h %h want c%0d %h %h", o.c - s, o.a, o.d, e.c - s, e.a, e.d);
                end
            end
        end
        n_cmp++; if (oi != obs_q.size()) begin n_fail++; $display("FAIL ignore_extra_writes: got %0d want 0", obs_q.size() - oi); end
    endtask

    task automatic test_reset_mid();
        int oi, di, rel, s1;
        wr_t e, o;
        logic [MW-1:0] m;
        m = rand_mat(); mem_ready = 1'b1;
        oi = obs_q.size(); di = done_q.size();
        do_start(9'h060, m);
        s1 = s;
        push_exp(9'h060, m, s1, 5, NW, 0);
        for (int i = 0; i < 20; i++) begin
            rel = cyc - s1;
            if (rel == 7) begin reset = 1'b1; mem_ready = 1'b0; end
            if (rel == 8) begin reset = 1'b0; mem_ready = 1'b1; end
            @(negedge clk);
            if (rel == 8) begin
                n_cmp++;
                if (mem_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++; $display("FAIL abort_outputs: got wr%b busy%b done%b want 000", mem_wr, busy, done);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (done_q.size() != di) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_q.size() - di); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (oi >= obs_q.size()) begin n_fail++; $display("FAIL abort_missing_write: addr %h not seen", e.a); end
            else begin
                o = obs_q[oi]; oi++;
                if (o.c != e.c || o.a !== e.a || o.d !== e.d) begin
                    n_fail++; $display("FAIL abort_write: got c%0d %h %h want c%0d %h %h", o.c - s1, o.a, o.d, e.c - s1, e.a, e.d);
                end
            end
        end
        n_cmp++; if (oi != obs_q.size()) begin n_fail++; $display("FAIL abort_extra_writes: got %0d want 0", obs_q.size() - oi); end
        m = rand_mat();
        do_start(9'h0A0, m);
        push_exp(9'h0A0, m, s, NW, NW, 0);
        for (int i = 0; i < 40 && done_q.size() == di; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_q.size() != di + 1 || done_q[di] != s + 15) begin
            n_fail++; $display("FAIL after_abort_done: got %0d pulses want one at cycle 15", done_q.size() - di);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (oi >= obs_q.size()) begin n_fail++; $display("FAIL after_abort_missing_write: addr %h not seen", e.a); end
            else begin
                o = obs_q[oi]; oi++;
                if (o.c != e.c || o.a !== e.a || o.d !== e.d) begin
                    n_fail++; $display("FAIL after_abort_write: got c%0d %h %h want c%0d %h %h", o.c - s, o.a, o.d, e.c - s, e.a, e.d);
                end
            end
        end
        n_cmp++; if (oi != obs_q.size()) begin n_fail++; $display("FAIL after_abort_extra: got %0d want 0", obs_q.size() - oi); end
    endtask

    task automatic test_finish_start();
        int oi, di, rel;
        wr_t e, o;
        logic [MW-1:0] m1, m2;
        m1 = rand_mat(); m2 = rand_mat(); mem_ready = 1'b1;
        oi = obs_q.size(); di = done_q.size();
        do_start(9'h010, m1);
        push_exp(9'h010, m1, s, NW, NW, 0);
        push_exp(9'h0C0, m2, s + 16, NW, NW, 0);
        for (int i = 0; i < 45; i++) begin
            rel = cyc - s;
            if (rel == 15) begin start = 1'b1; base_addr = 9'h0C0; matrix_C = m2; end
            if (rel == 17) start = 1'b0;
            @(negedge clk);
            if (rel == 16) begin
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL finish_start_busy16: got %b want 0", busy); end
            end
            if (rel == 17) begin
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL finish_start_busy17: got %b want 1", busy); end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done_q.size() != di + 2 || done_q[di] != s + 15 || done_q[di+1] != s + 31) begin
            n_fail++; $display("FAIL finish_start_done: got %0d pulses want two at cycles 15 and 31", done_q.size() - di);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (oi >= obs_q.size()) begin n_fail++; $display("FAIL finish_start_missing_write: addr %h not seen", e.a); end
            else begin
                o = obs_q[oi]; oi++;
                if (o.c != e.c || o.a !== e.a || o.d !== e.d) begin
                    n_fail++; $display("FAIL finish_start_write: got c%0d %h %h want c%0d %h %h", o.c - s, o.a, o.d, e.c - s, e.a, e.d);
                end
            end
        end
        n_cmp++; if (oi != obs_q.size()) begin n_fail++; $display("FAIL finish_start_extra: got %0d want 0", obs_q.size() - oi); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_ignore_start();
        test_reset_mid();
        test_finish_start();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
